// File: rtl/wb_serial_bridge_pkg.sv
// Constants and state encoding shared by wb_serial_bridge and the remote serial_wb_master.
package wb_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] STATUS_OK = 8'h00;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wb_serial_bridge_if.sv
// Pipelined Wishbone slave port plus the outbound/inbound byte streams of the bridge.
// Byte streams: a byte moves on a rising clk edge where tvalid and tready are both high;
// the sender holds tvalid and tdata stable until that edge and never withdraws a byte.
interface wb_serial_bridge_if #(
  parameter int BYTES     = 1,
  parameter int ADDR_BITS = 8,
  parameter int SEL_WIDTH = BYTES
);
  logic [ADDR_BITS-1:0] s_wb_addr;
  logic [BYTES*8-1:0]   s_wb_dat_m2s;
  logic [BYTES*8-1:0]   s_wb_dat_s2m;
  logic                 s_wb_we;
  logic [SEL_WIDTH-1:0] s_wb_sel;
  logic                 s_wb_stb;
  logic                 s_wb_cyc;
  logic                 s_wb_ack;
  logic                 s_wb_err;
  logic                 s_wb_stall;
  logic                 axis_o_tready;
  logic                 axis_o_tvalid;
  logic [7:0]           axis_o_tdata;
  logic                 axis_i_tready;
  logic                 axis_i_tvalid;
  logic [7:0]           axis_i_tdata;

  modport slave (
    input  s_wb_addr, s_wb_dat_m2s, s_wb_we, s_wb_sel, s_wb_stb, s_wb_cyc,
    output s_wb_dat_s2m, s_wb_ack, s_wb_err, s_wb_stall,
    input  axis_o_tready,
    output axis_o_tvalid, axis_o_tdata,
    output axis_i_tready,
    input  axis_i_tvalid, axis_i_tdata
  );

  modport master (
    output s_wb_addr, s_wb_dat_m2s, s_wb_we, s_wb_sel, s_wb_stb, s_wb_cyc,
    input  s_wb_dat_s2m, s_wb_ack, s_wb_err, s_wb_stall,
    output axis_o_tready,
    input  axis_o_tvalid, axis_o_tdata,
    input  axis_i_tready,
    output axis_i_tvalid, axis_i_tdata
  );
endinterface

// File: rtl/wb_serial_bridge_timeout.sv
// Response watchdog: loadable down-counter; expired_o rises after TIMEOUT_CYCLES enabled cycles.
module wb_serial_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  // Loading T-1 makes the flag fire in the T-th enabled cycle after the load.
  localparam logic [W-1:0] RELOAD = (TIMEOUT_CYCLES == 0) ? '0 : W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= RELOAD;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == '0);

endmodule

// File: rtl/wb_serial_bridge.sv
// Wishbone slave that serialises one bus cycle at a time into a command frame and
// turns the reply frame into ack/err; the debug state_o mirrors the FSM.
module wb_serial_bridge
  import wb_serial_pkg::*;
#(
  parameter int BYTES          = 1,
  parameter int ADDR_BITS      = 8,
  parameter int SEL_WIDTH      = BYTES,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                sresetn,
  wb_serial_bridge_if.slave   bus,
  output state_e              state_o
);
  localparam int ADDR_BYTES = (ADDR_BITS + 7) / 8;
  localparam int AW         = ADDR_BYTES * 8;
  localparam int DW         = BYTES * 8;
  localparam int CNT_W      = $clog2(max_int(ADDR_BYTES, BYTES) + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             we_q, we_d;
  logic             ok_q, ok_d;
  logic             live_q, live_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic tx_hs, rx_ready, rx_hs, expired;
  wire  unused_sel = &{1'b0, bus.s_wb_sel};

  assign tx_hs    = tx_valid_q & bus.axis_o_tready;
  assign rx_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign rx_hs    = rx_ready & bus.axis_i_tvalid;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    ok_d       = ok_q;
    live_d     = live_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    // A master abandoning the cycle only silences the final pulse; the frame runs on.
    if (state_q != ST_IDLE && !bus.s_wb_cyc) live_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.s_wb_cyc && bus.s_wb_stb) begin
          addr_d     = AW'(bus.s_wb_addr);
          data_d     = bus.s_wb_dat_m2s;
          we_d       = bus.s_wb_we;
          live_d     = 1'b1;
          cnt_d      = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = bus.s_wb_we ? CMD_WRITE : CMD_READ;
          state_d    = ST_CMD;
        end
      end
      ST_CMD: begin
        if (tx_hs) begin
          tx_data_d = addr_q[AW-1 -: 8];
          addr_d    = addr_q << 8;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (tx_hs) begin
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            if (we_q) begin
              tx_data_d = data_q[DW-1 -: 8];
              data_d    = data_q << 8;
              state_d   = ST_DATA;
            end else begin
              tx_valid_d = 1'b0;
              state_d    = ST_RESP;
            end
          end else begin
            cnt_d     = cnt_q + CNT_ONE;
            tx_data_d = addr_q[AW-1 -: 8];
            addr_d    = addr_q << 8;
          end
        end
      end
      ST_DATA: begin
        if (tx_hs) begin
          if (cnt_q == DATA_LAST) begin
            cnt_d      = '0;
            tx_valid_d = 1'b0;
            state_d    = ST_RESP;
          end else begin
            cnt_d     = cnt_q + CNT_ONE;
            tx_data_d = data_q[DW-1 -: 8];
            data_d    = data_q << 8;
          end
        end
      end
      ST_RESP: begin
        if (rx_hs) begin
          if (we_q) begin
            ok_d    = (bus.axis_i_tdata == STATUS_OK);
            state_d = ST_DONE;
          end else begin
            rdata_d = (rdata_q << 8) | DW'(bus.axis_i_tdata);
            if (cnt_q == DATA_LAST) begin
              ok_d    = 1'b1;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end else if (expired) begin
          ok_d    = 1'b0;
          rdata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      ok_q       <= 1'b0;
      live_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      ok_q       <= ok_d;
      live_q     <= live_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  wb_serial_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .rst_n     (sresetn),
    .load_i    (((state_d == ST_RESP) && (state_q != ST_RESP)) || ((state_q == ST_RESP) && rx_hs)),
    .clr_i     (state_q != ST_RESP),
    .en_i      (state_q == ST_RESP),
    .expired_o (expired)
  );

  assign bus.s_wb_stall    = (state_q != ST_IDLE);
  assign bus.s_wb_ack      = (state_q == ST_DONE) && live_q && bus.s_wb_cyc && ok_q;
  assign bus.s_wb_err      = (state_q == ST_DONE) && live_q && bus.s_wb_cyc && !ok_q;
  assign bus.s_wb_dat_s2m  = rdata_q;
  assign bus.axis_o_tvalid = tx_valid_q;
  assign bus.axis_o_tdata  = tx_data_q;
  assign bus.axis_i_tready = rx_ready;
  assign state_o           = state_q;

endmodule

// File: tb/tb_wb_serial_bridge.sv
// Scoreboarded bench for wb_serial_bridge: frame bytes and completions are predicted when issued.
module tb_wb_serial_bridge;
  import wb_serial_pkg::*;

  logic   clk = 1'b0;
  logic   sresetn = 1'b0;
  state_e state;

  wb_serial_bridge_if #(.BYTES(1), .ADDR_BITS(8)) bus ();

  wb_serial_bridge #(.BYTES(1), .ADDR_BITS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .sresetn (sresetn),
    .bus     (bus),
    .state_o (state)
  );

  always #5 clk = ~clk;

  // Scoreboard: outbound bytes, and completions as {check_data, err, ack, data}.
  logic [7:0]  exp_q[$];
  logic [10:0] resp_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int tx_count = 0;
  int tready_mode = 0;
  bit tog = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic [10:0] mon_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive link tready first, then judge what the next rising edge will do.
  always @(negedge clk) begin
    tog = ~tog;
    bus.axis_o_tready = (tready_mode == 0) ? 1'b1 : (tready_mode == 1) ? tog : 1'b0;
    if (!sresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("tdata_hold", bus.axis_o_tdata, prev_data);
        check("tvalid_hold", bus.axis_o_tvalid, 1);
      end
      if (bus.axis_o_tvalid && bus.axis_o_tready) begin
        tx_count++;
        if (exp_q.size() == 0) check("unexpected_byte", bus.axis_o_tdata, 32'h100);
        else check("tx_byte", bus.axis_o_tdata, exp_q.pop_front());
      end
      if (bus.s_wb_ack || bus.s_wb_err) begin
        check("ack_err_excl", bus.s_wb_ack & bus.s_wb_err, 0);
        if (resp_q.size() == 0) begin
          check("unexpected_done", {bus.s_wb_err, bus.s_wb_ack}, 0);
        end else begin
          mon_r = resp_q.pop_front();
          check("done_flags", {bus.s_wb_err, bus.s_wb_ack}, mon_r[9:8]);
          if (mon_r[10]) check("rd_data", bus.s_wb_dat_s2m, mon_r[7:0]);
        end
      end
      prev_stall = bus.axis_o_tvalid && !bus.axis_o_tready;
      prev_data  = bus.axis_o_tdata;
    end
  end

  task automatic check_reset_values();
    check("rst_ack", bus.s_wb_ack, 0);
    check("rst_err", bus.s_wb_err, 0);
    check("rst_stall", bus.s_wb_stall, 0);
    check("rst_o_tvalid", bus.axis_o_tvalid, 0);
    check("rst_i_tready", bus.axis_i_tready, 1);
    check("rst_dat_s2m", bus.s_wb_dat_s2m, 0);
    check("rst_state", state, ST_IDLE);
  endtask

  // Called just after a falling edge; issues one bus cycle and predicts its frame.
  task automatic wb_req(input logic we, input logic [7:0] addr, input logic [7:0] data);
    int n = 0;
    while (bus.s_wb_stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("req_wait", 1, 0);
    bus.s_wb_cyc     = 1'b1;
    bus.s_wb_stb     = 1'b1;
    bus.s_wb_we      = we;
    bus.s_wb_addr    = addr;
    bus.s_wb_dat_m2s = data;
    exp_q.push_back(we ? CMD_WRITE : CMD_READ);
    exp_q.push_back(addr);
    if (we) exp_q.push_back(data);
    @(negedge clk);
    bus.s_wb_stb = 1'b0;
    check("tvalid_after_accept", bus.axis_o_tvalid, 1);
    check("stall_after_accept", bus.s_wb_stall, 1);
  endtask

  task automatic send_resp(input logic [7:0] b);
    int n = 0;
    bus.axis_i_tvalid = 1'b1;
    bus.axis_i_tdata  = b;
    while (!bus.axis_i_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("resp_wait", 1, 0);
    @(negedge clk);
    bus.axis_i_tvalid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(bus.s_wb_ack || bus.s_wb_err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("done_wait", 1, 0);
    @(negedge clk);
    check("done_one_cycle", {bus.s_wb_err, bus.s_wb_ack}, 0);
    check("stall_after_done", bus.s_wb_stall, 0);
    bus.s_wb_cyc = 1'b0;
  endtask

  task automatic wait_state(input state_e s);
    int n = 0;
    while (state != s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("state_wait", state, s);
  endtask

  task automatic full_txn(input logic we, input logic [7:0] addr, input logic [7:0] data,
                          input logic [7:0] reply);
    if (we) resp_q.push_back({1'b0, reply != STATUS_OK, reply == STATUS_OK, 8'h00});
    else    resp_q.push_back({1'b1, 1'b0, 1'b1, reply});
    wb_req(we, addr, data);
    send_resp(reply);
    check("resp_to_done", bus.s_wb_ack | bus.s_wb_err, 1);
    wait_done();
  endtask

  initial begin
    int cnt;
    int sent0;
    bus.s_wb_cyc = 1'b0;  bus.s_wb_stb = 1'b0;  bus.s_wb_we = 1'b0;
    bus.s_wb_addr = '0;   bus.s_wb_dat_m2s = '0; bus.s_wb_sel = '1;
    bus.axis_i_tvalid = 1'b0; bus.axis_i_tdata = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    sresetn = 1'b1;
    @(negedge clk);
    check_reset_values();

    full_txn(1'b1, 8'h05, 8'hA5, 8'h00);
    full_txn(1'b0, 8'h84, 8'h00, 8'h3C);
    full_txn(1'b1, 8'h12, 8'h34, 8'h01);

    // Silent peer: err must land exactly 16 cycles after RESP is entered.
    resp_q.push_back({1'b0, 1'b1, 1'b0, 8'h00});
    wb_req(1'b0, 8'h22, 8'h00);
    wait_state(ST_RESP);
    cnt = 0;
    while (!bus.s_wb_err && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_cycles", cnt, 16);
    @(negedge clk);
    bus.s_wb_cyc = 1'b0;
    check("timeout_idle", state, ST_IDLE);
    bus.axis_i_tvalid = 1'b1;
    bus.axis_i_tdata  = 8'h99;
    @(negedge clk);
    bus.axis_i_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("late_byte_idle", state, ST_IDLE);

    tready_mode = 1;
    sent0 = tx_count;
    full_txn(1'b1, 8'h3A, 8'hC3, 8'h00);
    check("toggle_byte_count", tx_count - sent0, 3);
    tready_mode = 0;

    for (int i = 0; i < 4; i++) begin
      logic we_r;
      logic [7:0] a_r, d_r;
      we_r = 1'($urandom_range(0, 1));
      a_r  = 8'($urandom_range(0, 255));
      d_r  = 8'($urandom_range(0, 255));
      full_txn(we_r, a_r, d_r, we_r ? 8'h00 : d_r);
    end

    // Reset in the middle of the address phase.
    tready_mode = 1;
    wb_req(1'b1, 8'h10, 8'h20);
    wait_state(ST_ADDR);
    sresetn = 1'b0;
    exp_q.delete();
    bus.s_wb_cyc = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    sresetn = 1'b1;
    tready_mode = 0;
    @(negedge clk);
    full_txn(1'b1, 8'h07, 8'h5A, 8'h00);

    // Cycle abandoned during RESP: frame completes, no pulse.
    wb_req(1'b0, 8'h40, 8'h00);
    wait_state(ST_RESP);
    bus.s_wb_cyc = 1'b0;
    send_resp(8'h77);
    repeat (4) @(negedge clk);
    check("abandon_idle", state, ST_IDLE);

    full_txn(1'b0, 8'hFF, 8'h00, 8'hE1);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("resp_q_empty", resp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_serial_bridge.md
# wb_serial_bridge

Wishbone-to-byte-stream bridge: a pipelined Wishbone slave that encodes each accepted transaction into a serial command frame and decodes the reply frame into a Wishbone ack or error. It drives a UART or other byte-stream link to a remote `serial_wb_master`, so one FPGA (or a bench) can issue bus cycles on another. It carries one transaction at a time and has a response timeout.

## Interface
Parameters:
- `BYTES`, 1: Wishbone data width in bytes.
- `ADDR_BITS`, 8: Wishbone address width.
- `SEL_WIDTH`, BYTES: byte-select width.
- `TIMEOUT_CYCLES`, 1_000_000: idle `clk` cycles allowed between response bytes. 0 disables the timeout.

Ports:
- `clk`  in  1  clock.
- `sresetn`  in  1  reset, asynchronous, active-low.
- `s_wb_addr`  in  ADDR_BITS  address.
- `s_wb_dat_m2s`  in  BYTES*8  write data.
- `s_wb_dat_s2m`  out  BYTES*8  read data, valid with `s_wb_ack`.
- `s_wb_we`  in  1  write enable.
- `s_wb_sel`  in  SEL_WIDTH  byte selects; ignored, full-width transfers only.
- `s_wb_stb`, `s_wb_cyc`  in  1  strobe and cycle.
- `s_wb_ack`  out  1  completion pulse.
- `s_wb_err`  out  1  error pulse.
- `s_wb_stall`  out  1  request not accepted.
- `axis_o_tready`  in  1  link accepts a byte.
- `axis_o_tvalid`  out  1  request byte valid.
- `axis_o_tdata`  out  8  request byte.
- `axis_i_tready`  out  1  bridge accepts a response byte.
- `axis_i_tvalid`  in  1  response byte valid.
- `axis_i_tdata`  in  8  response byte.

## Operation
- `ADDR_BYTES = (ADDR_BITS+7)/8`. The address is zero-extended to `ADDR_BYTES*8`. Multi-byte fields are sent MSB byte first.
- Request frame: the command byte (8'h00 read, 8'h01 write), then `ADDR_BYTES` address bytes, then `BYTES` data bytes (writes only).
- Response frame:
  - Read: `BYTES` data bytes, MSB first.
  - Write: one status byte. 8'h00 gives ack; any other value gives err.
- State machine:
  - IDLE: `s_wb_stall`=0, `axis_i_tready`=1 so stray bytes are discarded. On `s_wb_cyc & s_wb_stb`, latch addr, data and we, then go to CMD.
  - CMD: present the command byte. Go to ADDR on handshake.
  - ADDR: present address bytes. After the last handshake go to DATA if write, else RESP.
  - DATA: present data bytes. After the last handshake go to RESP.
  - RESP: `axis_i_tready`=1. Shift bytes into the read-data register or capture the status byte. After the final byte go to DONE.
  - DONE: pulse `s_wb_ack` or `s_wb_err` for one cycle, then go to IDLE.
- In every state except IDLE: `s_wb_stall`=1, and `axis_i_tready`=1 only in RESP.
- Timeout: a counter clears on entry to RESP and on each accepted response byte. When it reaches `TIMEOUT_CYCLES`, go to DONE and assert err. Partial read data is discarded.
- `s_wb_cyc` dropped after acceptance: the link frame still completes (frames are never truncated), and the DONE ack/err pulse is suppressed.

## Timing
- Reset values:
  - outputs: `s_wb_ack`=0, `s_wb_err`=0, `s_wb_stall`=0, `axis_o_tvalid`=0, `axis_i_tready`=1, `s_wb_dat_s2m`=0.
  - state: state=IDLE, counters=0.
- Reset asserted mid-frame aborts immediately. The link peer must resynchronise.
- Acceptance to first `axis_o_tvalid`: 1 cycle.
- `axis_o_tvalid`/`axis_o_tdata` are registered and held stable until `axis_o_tready`. There are no bubbles between request bytes when tready is continuously high.
- Final response byte handshake to `s_wb_ack`: 1 cycle. `s_wb_stall` deasserts in the cycle after the ack.
- Read with all ready/valid high: 1 accept + (1+ADDR_BYTES) request + BYTES response + 1 done cycles.
- `s_wb_ack` and `s_wb_err` are never both asserted.

## Structure
- `wb_serial_pkg`: the state enum, `CMD_READ`=8'h00, `CMD_WRITE`=8'h01, `STATUS_OK`=8'h00. `serial_wb_master` shares these constants.
- One byte counter, width `$clog2(max(ADDR_BYTES,BYTES)+1)`, reused across ADDR, DATA and RESP.
- Sub-module `wb_serial_timeout`: a loadable down-counter with clear and an expired flag.

## Test plan
- Write addr 8'h05, data 8'hA5, tready=1 -> bytes 01,05,A5 on `axis_o`. Respond 00 -> one-cycle ack, stall low the next cycle.
- Read addr 8'h84 -> bytes 00,84. Respond 3C -> ack with `s_wb_dat_s2m`=8'h3C.
- Write with status reply 8'h01 -> err pulse, no ack.
- Read with `TIMEOUT_CYCLES`=16 and no reply -> err exactly 16 cycles after entering RESP, then IDLE. A late reply byte is discarded.
- `axis_o_tready` toggling 1/0 each cycle during a write -> tdata stable while stalled, exactly 3 bytes sent in order.
- Reset asserted during ADDR -> all outputs at reset values. The next transaction frames correctly. Also drive `s_wb_cyc`=0 during RESP -> no ack.
